// File: rtl/rename_map_if.sv
// Signal bundle between decode/execute/ROB and the rename_map stage.
interface rename_map_if;
    logic         STALL;
    logic         FLUSH;
    logic         issue_halt;
    logic         dec_valid;
    logic [151:0] dec_info;
    logic [4:0]   dec_srcA;
    logic [4:0]   dec_srcB;
    logic [4:0]   dec_srcC;
    logic         dec_dest_en;
    logic [4:0]   dec_dest;
    logic         exe_broadcast;
    logic [5:0]   exe_broadcast_map;
    logic         rob_commit;
    logic [4:0]   rob_commit_arch;
    logic [5:0]   rob_commit_map;
    logic [5:0]   rob_commit_old;
    logic         dec_ready;
    logic         rename_enque;
    logic [169:0] rename_issueinfo;
    logic [31:0]  rename_instr_num;
    logic [5:0]   rename_old_map;
    logic [63:0]  busy;

    modport master (
        output STALL, FLUSH, issue_halt, dec_valid, dec_info, dec_srcA, dec_srcB,
               dec_srcC, dec_dest_en, dec_dest, exe_broadcast, exe_broadcast_map,
               rob_commit, rob_commit_arch, rob_commit_map, rob_commit_old,
        input  dec_ready, rename_enque, rename_issueinfo, rename_instr_num,
               rename_old_map, busy
    );

    modport slave (
        input  STALL, FLUSH, issue_halt, dec_valid, dec_info, dec_srcA, dec_srcB,
               dec_srcC, dec_dest_en, dec_dest, exe_broadcast, exe_broadcast_map,
               rob_commit, rob_commit_arch, rob_commit_map, rob_commit_old,
        output dec_ready, rename_enque, rename_issueinfo, rename_instr_num,
               rename_old_map, busy
    );
endinterface

// File: rtl/rename_map.sv
// Register rename stage: speculative and retirement RATs, a circular free list
// of physical registers, the busy vector and a one-cycle registered rename output.
module rename_map (
    input  logic        CLK,
    input  logic        RESET,
    rename_map_if.slave bus
);
    logic [5:0]   rat_q  [32];
    logic [5:0]   rat_d  [32];
    logic [5:0]   rrat_q [32];
    logic [5:0]   rrat_d [32];
    logic [5:0]   fl_q   [64];
    logic [5:0]   fl_d   [64];
    logic [5:0]   head_q, head_d;
    logic [5:0]   tail_q, tail_d;
    logic [5:0]   rhead_q, rhead_d;
    logic [63:0]  busy_q, busy_d;
    logic         enque_q, enque_d;
    logic [169:0] info_q, info_d;
    logic [31:0]  num_q, num_d;
    logic [31:0]  seq_q, seq_d;
    logic [5:0]   old_q, old_d;

    logic       needsAlloc;
    logic       flEmpty;
    logic       accept;
    logic [5:0] mapA;
    logic [5:0] mapB;
    logic [5:0] mapWr;

    // At most 32 registers are ever free, so head == tail can only mean empty.
    assign needsAlloc = bus.dec_dest_en && (bus.dec_dest != 5'd0);
    assign flEmpty    = (head_q == tail_q);
    assign accept     = bus.dec_valid && !bus.STALL && !bus.issue_halt && !bus.FLUSH &&
                        !RESET && (!needsAlloc || !flEmpty);

    assign mapA  = rat_q[bus.dec_srcA];
    assign mapB  = rat_q[bus.dec_srcB];
    assign mapWr = needsAlloc ? fl_q[head_q] : rat_q[bus.dec_srcC];

    assign bus.dec_ready        = accept;
    assign bus.rename_enque     = enque_q;
    assign bus.rename_issueinfo = info_q;
    assign bus.rename_instr_num = num_q;
    assign bus.rename_old_map   = old_q;
    assign bus.busy             = busy_q;

    always_comb begin
        rat_d   = rat_q;
        rrat_d  = rrat_q;
        fl_d    = fl_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rhead_d = rhead_q;
        busy_d  = busy_q;
        enque_d = 1'b0;
        info_d  = info_q;
        num_d   = num_q;
        seq_d   = seq_q;
        old_d   = old_q;

        if (bus.rob_commit) begin
            if (bus.rob_commit_arch != 5'd0) begin
                rrat_d[bus.rob_commit_arch] = bus.rob_commit_map;
                rhead_d = rhead_q + 6'd1;
            end
            if (bus.rob_commit_old != 6'd0) begin
                fl_d[tail_q] = bus.rob_commit_old;
                tail_d       = tail_q + 6'd1;
            end
        end

        if (bus.exe_broadcast && (bus.exe_broadcast_map != 6'd0)) begin
            busy_d[bus.exe_broadcast_map] = 1'b1;
        end

        // Flush rolls back to the committed state, including this cycle's commit.
        if (bus.FLUSH) begin
            rat_d  = rrat_d;
            head_d = rhead_d;
            busy_d = '1;
        end else if (accept) begin
            enque_d = 1'b1;
            info_d  = {bus.dec_info, mapWr, mapB, mapA};
            num_d   = seq_q;
            seq_d   = seq_q + 32'd1;
            old_d   = rat_q[bus.dec_dest];
            if (needsAlloc) begin
                rat_d[bus.dec_dest] = mapWr;
                head_d              = head_q + 6'd1;
                busy_d[mapWr]       = 1'b0;
            end
        end

        rat_d[0]  = 6'd0;
        rrat_d[0] = 6'd0;
        busy_d[0] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                rat_q[i]  <= 6'(i);
                rrat_q[i] <= 6'(i);
            end
            for (int i = 0; i < 64; i++) begin
                fl_q[i] <= (i < 32) ? 6'(i + 32) : 6'd0;
            end
            head_q  <= 6'd0;
            tail_q  <= 6'd32;
            rhead_q <= 6'd0;
            busy_q  <= '1;
            enque_q <= 1'b0;
            info_q  <= '0;
            num_q   <= 32'd0;
            seq_q   <= 32'd0;
            old_q   <= 6'd0;
        end else begin
            rat_q   <= rat_d;
            rrat_q  <= rrat_d;
            fl_q    <= fl_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rhead_q <= rhead_d;
            busy_q  <= busy_d;
            enque_q <= enque_d;
            info_q  <= info_d;
            num_q   <= num_d;
            seq_q   <= seq_d;
            old_q   <= old_d;
        end
    end
endmodule
